countmod9_ctrl: RTL
===================

Name: countmod9_ctrl

Overview:
Input-conditioning and command stage that sits directly upstream of the mod-9 counter and drives its mode, load_val and sync_reset inputs. It synchronises and debounces the raw board switches and buttons, and turns button presses into single-cycle LOAD commands and a 2-cycle sync_reset pulse. A prescaler gates the INC_ONE and DEC_TWO modes so the counter steps once per tick instead of once per clock.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles before a synchronised input is accepted (10 ms at 50 MHz)
TICK_DIV, 50000000, clk cycles per counting tick (1 Hz at 50 MHz); must be >= 2

Ports:
clk  input  1  system clock, 50 MHz
async_reset  input  1  asynchronous, active-high reset
sw_mode  input  2  raw mode switches: 00 STOP, 01 INC_ONE, 11 DEC_TWO, 10 LOAD
sw_val  input  4  raw load-value switches
btn_load  input  1  raw load button, active-high
btn_reset  input  1  raw counter-reset button, active-high
mode  output  2  command to the counter
load_val  output  4  value to the counter, held stable
sync_reset  output  1  synchronous reset to the counter
tick_led  output  1  toggles on every prescaler tick

Behaviour:
- Reset: async_reset is asynchronous and active-high. It clears all flops: mode=00, load_val=0000, sync_reset=0, tick_led=0, state=RUN, prescaler=0, debounce counters=0, and the synchroniser and debounced values=0.
- Because debounced values clear to 0, a button held through reset produces one press edge after the debounce time.
- Synchronisers: two flops on every raw input.
- Debounce: four independent groups (sw_mode vector, sw_val vector, btn_load, btn_reset).
  - Each group has a counter that restarts on any change of the synchronised value.
  - The debounced value updates when the synchronised value has been unchanged for DEBOUNCE_CYCLES consecutive cycles.
  - Vectors are debounced as a whole.
- Edge detect: a press is a debounced 0->1 transition. Each press is a one-cycle internal event.
- Prescaler: counts 0..TICK_DIV-1, asserts tick for the single cycle at TICK_DIV-1, then wraps to 0.
  - Clears to 0 when debounced sw_mode changes and when entering RST1.
  - tick_led toggles on each tick.
- FSM states: RUN, LOAD, RST1, RST2. All outputs are registered.
  - RUN, reset press: -> RST1. Highest priority.
  - RUN, load press (no reset press): -> LOAD. load_val <= debounced sw_val.
  - RUN, otherwise, sw_mode 01 or 11: mode = sw_mode on tick cycles, 00 on all other cycles.
  - RUN, otherwise, sw_mode 00 or 10: mode = 00. LOAD is never issued from the switches, only from btn_load.
  - LOAD: mode=10 for exactly one cycle -> RUN. A tick coinciding with LOAD is dropped.
  - RST1, RST2: sync_reset=1, mode=00. RST1 -> RST2 -> RUN, giving exactly 2 cycles.
  - Presses of either button during LOAD/RST1/RST2 are dropped, not queued.
- load_val changes only on LOAD entry and stays constant otherwise.
- Latency:
  - Raw edge to debounced value: 2 + DEBOUNCE_CYCLES cycles.
  - Debounced press to mode/sync_reset output: 1 cycle.
- Simultaneous reset and load presses: reset is taken, load is discarded.
- async_reset mid-LOAD or mid-RST: outputs clear immediately; no partial pulse resumes after release.

Test Plan (DEBOUNCE_CYCLES=4, TICK_DIV=5, 20 ns clk):
1. async_reset held 1 cycle at t=5 ns, then released -> mode=00, load_val=0000, sync_reset=0, tick_led=0 throughout and after; an async_reset pulse mid-count clears all outputs within the same half-cycle.
2. sw_mode=01 held -> after debounce, mode=01 for 1 cycle in every 5, 00 otherwise; tick_led toggles every 5 cycles. Repeat with sw_mode=11 -> mode=11 pulses every 5 cycles.
3. sw_val=0101, btn_load high for 2 cycles (glitch) -> no LOAD. Then btn_load high for 10 cycles -> mode=10 for exactly 1 cycle, load_val=0101 from that cycle on. Release and re-press with sw_val=1111 -> load_val=1111.
4. btn_reset and btn_load rise on the same cycle, both held 10 cycles -> sync_reset=1 for exactly 2 cycles with mode=00; mode never equals 10.
5. sw_mode=10 held 20 cycles -> mode stays 00. Switch sw_mode 01->00 mid-run -> mode=00 one cycle after the debounced change, and the prescaler restarts from 0.
6. btn_load held across async_reset release -> exactly one LOAD pulse, 2+DEBOUNCE_CYCLES+1 cycles after release.

Source files
------------

// File: rtl/countmod9_ctrl.sv
// Input conditioning and command stage for the mod-9 counter: synchronises and
// debounces the board switches/buttons and issues mode, load_val and sync_reset.
module countmod9_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TICK_DIV        = 50000000
) (
    input  logic       clk,
    input  logic       async_reset,
    input  logic [1:0] sw_mode,
    input  logic [3:0] sw_val,
    input  logic       btn_load,
    input  logic       btn_reset,
    output logic [1:0] mode,
    output logic [3:0] load_val,
    output logic       sync_reset,
    output logic       tick_led
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    localparam logic [1:0] MODE_STOP = 2'b00;
    localparam logic [1:0] MODE_INC  = 2'b01;
    localparam logic [1:0] MODE_LOAD = 2'b10;
    localparam logic [1:0] MODE_DEC  = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LOAD,
        ST_RST1,
        ST_RST2
    } state_t;

    // Returns {accept, next_count}. A change of the synchronised value restarts
    // the count, but a value already held long enough is accepted first.
    function automatic logic [CW:0] db_next(input logic          differs,
                                            input logic          moving,
                                            input logic [CW-1:0] cnt);
        logic [CW:0] res;
        if (!differs) begin
            res = {1'b0, {CW{1'b0}}};
        end else if (cnt == CNT_LAST) begin
            res = {1'b1, {CW{1'b0}}};
        end else if (moving) begin
            res = {1'b0, {CW{1'b0}}};
        end else begin
            res = {1'b0, cnt + 1'b1};
        end
        return res;
    endfunction

    logic [7:0]    sync1_q;
    logic [7:0]    sync2_q;
    logic [1:0]    mode_s1;
    logic [1:0]    mode_s2;
    logic [3:0]    val_s1;
    logic [3:0]    val_s2;
    logic          ld_s1;
    logic          ld_s2;
    logic          rs_s1;
    logic          rs_s2;

    logic [CW-1:0] mode_cnt_q;
    logic [CW-1:0] val_cnt_q;
    logic [CW-1:0] ld_cnt_q;
    logic [CW-1:0] rs_cnt_q;
    logic [CW-1:0] mode_cnt_d;
    logic [CW-1:0] val_cnt_d;
    logic [CW-1:0] ld_cnt_d;
    logic [CW-1:0] rs_cnt_d;
    logic          mode_acc;
    logic          val_acc;
    logic          ld_acc;
    logic          rs_acc;

    logic [1:0]    mode_db_q;
    logic [3:0]    val_db_q;
    logic          ld_db_q;
    logic          rs_db_q;
    logic          ld_prev_q;
    logic          rs_prev_q;
    logic          ld_press;
    logic          rs_press;

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic          tick;
    logic          enter_rst;
    logic          tick_led_q;

    state_t        state_q;
    logic [1:0]    mode_q;
    logic [3:0]    load_val_q;
    logic          sync_reset_q;

    assign mode_s1 = sync1_q[7:6];
    assign mode_s2 = sync2_q[7:6];
    assign val_s1  = sync1_q[5:2];
    assign val_s2  = sync2_q[5:2];
    assign ld_s1   = sync1_q[1];
    assign ld_s2   = sync2_q[1];
    assign rs_s1   = sync1_q[0];
    assign rs_s2   = sync2_q[0];

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {sw_mode, sw_val, btn_load, btn_reset};
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        {mode_acc, mode_cnt_d} = db_next(mode_s2 != mode_db_q, mode_s1 != mode_s2, mode_cnt_q);
        {val_acc,  val_cnt_d}  = db_next(val_s2 != val_db_q,   val_s1 != val_s2,   val_cnt_q);
        {ld_acc,   ld_cnt_d}   = db_next(ld_s2 != ld_db_q,     ld_s1 != ld_s2,     ld_cnt_q);
        {rs_acc,   rs_cnt_d}   = db_next(rs_s2 != rs_db_q,     rs_s1 != rs_s2,     rs_cnt_q);
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            mode_cnt_q <= '0;
            val_cnt_q  <= '0;
            ld_cnt_q   <= '0;
            rs_cnt_q   <= '0;
            mode_db_q  <= '0;
            val_db_q   <= '0;
            ld_db_q    <= 1'b0;
            rs_db_q    <= 1'b0;
            ld_prev_q  <= 1'b0;
            rs_prev_q  <= 1'b0;
        end else begin
            mode_cnt_q <= mode_cnt_d;
            val_cnt_q  <= val_cnt_d;
            ld_cnt_q   <= ld_cnt_d;
            rs_cnt_q   <= rs_cnt_d;
            if (mode_acc) mode_db_q <= mode_s2;
            if (val_acc)  val_db_q  <= val_s2;
            if (ld_acc)   ld_db_q   <= ld_s2;
            if (rs_acc)   rs_db_q   <= rs_s2;
            ld_prev_q  <= ld_db_q;
            rs_prev_q  <= rs_db_q;
        end
    end

    assign ld_press  = ld_db_q & ~ld_prev_q;
    assign rs_press  = rs_db_q & ~rs_prev_q;
    assign enter_rst = (state_q == ST_RUN) && rs_press;
    assign tick      = (pre_q == PRE_LAST);

    // A new debounced mode or a counter reset restarts the tick phase.
    always_comb begin
        pre_d = pre_q + 1'b1;
        if (mode_acc || enter_rst || tick) begin
            pre_d = '0;
        end
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            pre_q      <= '0;
            tick_led_q <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            tick_led_q <= tick_led_q ^ tick;
        end
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state_q      <= ST_RUN;
            mode_q       <= MODE_STOP;
            load_val_q   <= '0;
            sync_reset_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (rs_press) begin
                        state_q      <= ST_RST1;
                        mode_q       <= MODE_STOP;
                        sync_reset_q <= 1'b1;
                    end else if (ld_press) begin
                        state_q      <= ST_LOAD;
                        mode_q       <= MODE_LOAD;
                        load_val_q   <= val_db_q;
                        sync_reset_q <= 1'b0;
                    end else begin
                        sync_reset_q <= 1'b0;
                        if (tick && (mode_db_q == MODE_INC || mode_db_q == MODE_DEC)) begin
                            mode_q <= mode_db_q;
                        end else begin
                            mode_q <= MODE_STOP;
                        end
                    end
                end
                ST_LOAD: begin
                    state_q      <= ST_RUN;
                    mode_q       <= MODE_STOP;
                    sync_reset_q <= 1'b0;
                end
                ST_RST1: begin
                    state_q      <= ST_RST2;
                    mode_q       <= MODE_STOP;
                    sync_reset_q <= 1'b1;
                end
                ST_RST2: begin
                    state_q      <= ST_RUN;
                    mode_q       <= MODE_STOP;
                    sync_reset_q <= 1'b0;
                end
                default: begin
                    state_q      <= ST_RUN;
                    mode_q       <= MODE_STOP;
                    sync_reset_q <= 1'b0;
                end
            endcase
        end
    end

    assign mode       = mode_q;
    assign load_val   = load_val_q;
    assign sync_reset = sync_reset_q;
    assign tick_led   = tick_led_q;

endmodule
